// File: rtl/driver_risk_scorer.sv
// Driver risk scorer: weighted |sample| sum, WIN-deep moving average, saturated score,
// persistence-filtered NORMAL/WARN/EMERG level with hysteresis and maskable sticky interrupts.
module driver_risk_scorer #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 8,
  parameter int unsigned WIN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                smp_valid,
  input  logic [NCH*DW-1:0]   smp_data,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [15:0]         wght_data,
  input  logic [1:0]          irq_mask,
  input  logic                irq_ack,
  output logic [1:0]          irq,
  output logic [15:0]         score,
  output logic                score_valid,
  output logic [1:0]          level
);

  localparam int unsigned PW = DW + 16;
  localparam int unsigned IW = PW + $clog2(NCH);
  localparam int unsigned LW = $clog2(WIN);
  localparam int unsigned AW = IW + LW;

  typedef enum logic [1:0] {
    S_NORMAL = 2'b00,
    S_WARN   = 2'b01,
    S_EMERG  = 2'b10
  } state_t;

  logic [15:0]   r_wght [NCH];
  logic [15:0]   r_warn_th;
  logic [15:0]   r_emerg_th;
  logic [15:0]   r_persist;
  logic [15:0]   r_hyst;

  logic [DW-1:0] w_abs  [NCH];
  logic [PW-1:0] r_prod [NCH];
  logic          r_v1;
  logic [IW-1:0] w_inst;
  logic [IW-1:0] r_inst;
  logic          r_v2;

  logic [IW-1:0] r_buf [WIN];
  logic [LW-1:0] r_ptr;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_acc_nxt;
  logic [IW-1:0] w_avg;
  logic [15:0]   w_score;

  logic [15:0]   r_score;
  logic          r_score_valid;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_wcnt, r_ecnt;
  logic [15:0]   w_wcnt_nxt, w_ecnt_nxt;
  logic [15:0]   w_pe, w_warn_lo, w_emerg_lo;
  logic [1:0]    w_set;
  logic [1:0]    r_pend, w_pend_nxt;
  logic [1:0]    r_irq, w_irq_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) r_wght[i] <= 16'd1;
      r_warn_th  <= '1;
      r_emerg_th <= '1;
      r_persist  <= 16'd1;
      r_hyst     <= '0;
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < NCH; i++)
        if (cfg_addr == 4'(i)) r_wght[i] <= wght_data;
      case (cfg_addr)
        4'd8:    r_warn_th  <= wght_data;
        4'd9:    r_emerg_th <= wght_data;
        4'd10:   r_persist  <= wght_data;
        4'd11:   r_hyst     <= wght_data;
        default: ;
      endcase
    end
  end

  // Two's-complement magnitude fits DW unsigned bits, including the most-negative value.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      w_abs[i] = smp_data[i*DW+DW-1] ? DW'(~smp_data[i*DW +: DW] + 1'b1)
                                     : smp_data[i*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= smp_valid;
      if (smp_valid)
        for (int unsigned i = 0; i < NCH; i++)
          r_prod[i] <= PW'(w_abs[i]) * PW'(r_wght[i]);
    end
  end

  always_comb begin
    w_inst = '0;
    for (int unsigned i = 0; i < NCH; i++) w_inst = w_inst + IW'(r_prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_inst <= w_inst;
    end
  end

  // Running sum of the window: the accumulator always equals the sum of r_buf.
  always_comb begin
    w_acc_nxt = r_acc + AW'(r_inst) - AW'(r_buf[r_ptr]);
    w_avg     = IW'(w_acc_nxt >> LW);
    w_score   = (w_avg > IW'(16'hFFFF)) ? 16'hFFFF : w_avg[15:0];
  end

  always_comb begin
    w_pe       = (r_persist == '0) ? 16'd1 : r_persist;
    w_warn_lo  = (r_warn_th  > r_hyst) ? r_warn_th  - r_hyst : '0;
    w_emerg_lo = (r_emerg_th > r_hyst) ? r_emerg_th - r_hyst : '0;
    w_wcnt_nxt = (w_score >= r_warn_th)  ? ((r_wcnt >= w_pe) ? w_pe : r_wcnt + 16'd1) : '0;
    w_ecnt_nxt = (w_score >= r_emerg_th) ? ((r_ecnt >= w_pe) ? w_pe : r_ecnt + 16'd1) : '0;
    w_state_nxt = r_state;
    w_set       = 2'b00;
    if (r_v2) begin
      case (r_state)
        S_NORMAL: begin
          if (w_ecnt_nxt >= w_pe) begin
            w_state_nxt = S_EMERG;
            w_set[1]    = 1'b1;
          end else if (w_wcnt_nxt >= w_pe) begin
            w_state_nxt = S_WARN;
            w_set[0]    = 1'b1;
          end
        end
        S_WARN: begin
          if (w_ecnt_nxt >= w_pe) begin
            w_state_nxt = S_EMERG;
            w_set[1]    = 1'b1;
          end else if (w_score < w_warn_lo) begin
            w_state_nxt = S_NORMAL;
          end
        end
        S_EMERG: begin
          if (w_score < w_warn_lo)
            w_state_nxt = S_NORMAL;
          else if (w_score < w_emerg_lo && w_score >= r_warn_th)
            w_state_nxt = S_WARN;
        end
        default: w_state_nxt = S_NORMAL;
      endcase
    end
    w_pend_nxt = irq_ack ? w_set : (r_pend | w_set);
    if (w_pend_nxt[1] && !irq_mask[1])      w_irq_nxt = 2'b10;
    else if (w_pend_nxt[0] && !irq_mask[0]) w_irq_nxt = 2'b01;
    else                                    w_irq_nxt = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIN; i++) r_buf[i] <= '0;
      r_ptr         <= '0;
      r_acc         <= '0;
      r_score       <= '0;
      r_score_valid <= 1'b0;
      r_state       <= S_NORMAL;
      r_wcnt        <= '0;
      r_ecnt        <= '0;
      r_pend        <= '0;
      r_irq         <= '0;
    end else begin
      r_score_valid <= r_v2;
      if (r_v2) begin
        r_buf[r_ptr] <= r_inst;
        r_ptr        <= r_ptr + 1'b1;
        r_acc        <= w_acc_nxt;
        r_score      <= w_score;
        r_wcnt       <= w_wcnt_nxt;
        r_ecnt       <= w_ecnt_nxt;
        r_state      <= w_state_nxt;
      end
      r_pend <= w_pend_nxt;
      r_irq  <= w_irq_nxt;
    end
  end

  assign score       = r_score;
  assign score_valid = r_score_valid;
  assign level       = r_state;
  assign irq         = r_irq;

endmodule

// File: tb/tb_driver_risk_scorer.sv
// Directed bench for driver_risk_scorer: a behavioural model pushes expected
// score/level/irq per sample; a negedge monitor pops and compares on score_valid.
module tb_driver_risk_scorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        smp_valid;
  logic [31:0] smp_data;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] wght_data;
  logic [1:0]  irq_mask;
  logic        irq_ack;
  logic [1:0]  irq;
  logic [15:0] score;
  logic        score_valid;
  logic [1:0]  level;

  driver_risk_scorer #(.NCH(4), .DW(8), .WIN(8)) dut (
    .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_data(smp_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .wght_data(wght_data),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .irq(irq), .score(score),
    .score_valid(score_valid), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] score;
    logic [1:0]  level;
    logic [1:0]  irq;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;

  longint m_hist[8];
  int     m_ptr;
  longint m_w[4];
  longint m_warn, m_emerg, m_persist, m_hyst;
  int     m_state;
  longint m_wc, m_ec;
  logic [1:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && score_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_score_valid: observed score_valid=1 expected 0 (no sample pending)");
      end else begin
        mon_e = sbq.pop_front();
        chk("score", 32'(score), 32'(mon_e.score));
        chk("level", 32'(level), 32'(mon_e.level));
        chk("irq",   32'(irq),   32'(mon_e.irq));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_hist[i] = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 1;
    m_ptr = 0; m_warn = 65535; m_emerg = 65535; m_persist = 1; m_hyst = 0;
    m_state = 0; m_wc = 0; m_ec = 0; m_pend = 2'b00;
    sbq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; smp_valid = 1'b0; cfg_we = 1'b0; irq_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 4'(addr); wght_data = 16'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < 4) m_w[addr] = data;
    else if (addr == 8)  m_warn = data;
    else if (addr == 9)  m_emerg = data;
    else if (addr == 10) m_persist = data;
    else if (addr == 11) m_hyst = data;
  endtask

  task automatic send(input int s0, input int s1, input int s2, input int s3);
    int s[4];
    longint inst, sum, sc, pe, wlo, elo;
    logic [1:0] set;
    exp_t e;
    s = '{s0, s1, s2, s3};
    smp_valid = 1'b1;
    smp_data  = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
    inst = 0;
    for (int i = 0; i < 4; i++) inst += longint'(s[i] < 0 ? -s[i] : s[i]) * m_w[i];
    m_hist[m_ptr] = inst;
    m_ptr = (m_ptr + 1) % 8;
    sum = 0;
    for (int i = 0; i < 8; i++) sum += m_hist[i];
    sc = sum / 8;
    if (sc > 65535) sc = 65535;
    pe  = (m_persist == 0) ? 1 : m_persist;
    wlo = (m_warn  > m_hyst) ? m_warn  - m_hyst : 0;
    elo = (m_emerg > m_hyst) ? m_emerg - m_hyst : 0;
    m_wc = (sc >= m_warn)  ? ((m_wc >= pe) ? pe : m_wc + 1) : 0;
    m_ec = (sc >= m_emerg) ? ((m_ec >= pe) ? pe : m_ec + 1) : 0;
    set = 2'b00;
    case (m_state)
      0: if (m_ec >= pe) begin m_state = 2; set = 2'b10; end
         else if (m_wc >= pe) begin m_state = 1; set = 2'b01; end
      1: if (m_ec >= pe) begin m_state = 2; set = 2'b10; end
         else if (sc < wlo) m_state = 0;
      default: if (sc < wlo) m_state = 0;
               else if (sc < elo && sc >= m_warn) m_state = 1;
    endcase
    m_pend = m_pend | set;
    e.score = 16'(sc);
    e.level = 2'(m_state);
    e.irq   = (m_pend[1] && !irq_mask[1]) ? 2'b10 :
              (m_pend[0] && !irq_mask[0]) ? 2'b01 : 2'b00;
    sbq.push_back(e);
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
    m_pend = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    smp_data = '0; cfg_addr = '0; wght_data = '0; irq_mask = 2'b00;
    do_reset();
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_score_valid", 32'(score_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Ramp to WARN then EMERG with constant inst 200
    cfg(0, 2); cfg(1, 3); cfg(2, 1); cfg(3, 4);
    cfg(8, 100); cfg(9, 180); cfg(10, 2); cfg(11, 10);
    for (int i = 0; i < 12; i++) send(40, -20, 20, 10);
    drain();
    chk("ramp_level", 32'(level), 32'd2);
    chk("ramp_irq", 32'(irq), 32'd2);

    // Masking with both bits pending
    irq_mask = 2'b10; @(posedge clk); #1; chk("mask10_irq", 32'(irq), 32'd1);
    irq_mask = 2'b11; @(posedge clk); #1; chk("mask11_irq", 32'(irq), 32'd0);
    irq_mask = 2'b00; @(posedge clk); #1; chk("unmask_irq", 32'(irq), 32'd2);
    ack(); chk("ack_irq", 32'(irq), 32'd0);

    // Decay through hysteresis bands
    for (int i = 0; i < 12; i++) send(0, 0, 0, 0);
    drain();
    chk("decay_level", 32'(level), 32'd0);

    // Single-score threshold crossing
    send(100, 100, 0, 0);
    for (int i = 0; i < 6; i++) send(0, 0, 0, 0);
    send(100, 100, 0, 0);
    for (int i = 0; i < 8; i++) send(0, 0, 0, 0);
    drain();
    chk("glitch_level", 32'(level), 32'd0);
    chk("glitch_irq", 32'(irq), 32'd0);

    // Most-negative sample, then 16-bit score saturation
    cfg(0, 1);
    for (int i = 0; i < 10; i++) send(-128, 0, 0, 0);
    drain();
    chk("neg_score", 32'(score), 32'd128);
    cfg(0, 65535); cfg(1, 65535); cfg(2, 65535); cfg(3, 65535);
    send(-128, -128, -128, -128);
    drain();
    chk("sat_score", 32'(score), 32'hFFFF);

    // Reset one cycle after a sample: no score_valid may follow
    send(5, 5, 5, 5);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("midrst_score", 32'(score), 32'd0);
    chk("midrst_score_valid", 32'(score_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Default config after reset, then persist = 0 acting as 1
    send(8, 8, 8, 8);
    drain();
    cfg(10, 0); cfg(8, 4);
    send(8, 8, 8, 8);
    drain();
    chk("persist0_level", 32'(level), 32'd1);

    // Direct NORMAL->EMERG with emergency masked
    do_reset();
    cfg(0, 2); cfg(1, 3); cfg(2, 1); cfg(3, 4);
    cfg(8, 100); cfg(9, 100); cfg(10, 2);
    irq_mask = 2'b10;
    for (int i = 0; i < 5; i++) send(40, -20, 20, 10);
    drain();
    chk("masked_level", 32'(level), 32'd2);
    chk("masked_irq", 32'(irq), 32'd0);
    irq_mask = 2'b00; @(posedge clk); #1; chk("unmasked_irq", 32'(irq), 32'd2);
    ack(); chk("acked_irq", 32'(irq), 32'd0);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/driver_risk_scorer.md
DRIVER_RISK_SCORER -- requirements
Module: driver_risk_scorer

Interface
REQ-001 Parameter NCH, default 4: number of signed sensor channels, range 1..8.
REQ-002 Parameter DW, default 8: sample width per channel, two's complement.
REQ-003 Parameter WIN, default 8: moving-average window depth, power of 2, range 2..64.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 smp_valid  in  1  qualifies smp_data for one cycle.
REQ-007 smp_data  in  NCH*DW  packed signed samples, channel 0 in LSBs.
REQ-008 cfg_we  in  1  config write strobe.
REQ-009 cfg_addr  in  4  config register address.
REQ-010 wght_data  in  16  config write data.
REQ-011 irq_mask  in  2  bit0 masks warning, bit1 masks emergency.
REQ-012 irq_ack  in  1  one-cycle pulse clearing all pending interrupts.
REQ-013 irq  out  2  01 = warning, 10 = emergency, 00 = none; never 11.
REQ-014 score  out  16  current windowed risk score, saturated.
REQ-015 score_valid  out  1  one-cycle pulse when score updates.
REQ-016 level  out  2  state: 00 NORMAL, 01 WARN, 10 EMERG.

Function
REQ-017 Config map: addr 0..NCH-1 weight[i]; 8 warn_th; 9 emerg_th; 10 persist; 11 hyst; other addresses ignored; write takes effect next cycle.
REQ-018 Stage 1, on smp_valid: prod[i] = |smp[i]| * weight[i], width DW+16; |most-negative| = 2^(DW-1), no overflow.
REQ-019 Stage 2: inst = sum of prod[i], full width, no truncation.
REQ-020 Stage 3: circular buffer of WIN inst values, write pointer wraps WIN-1 -> 0; acc += inst_new - inst_oldest; avg = acc >> log2(WIN).
REQ-021 Buffer and acc start at zero, so avg ramps up over the first WIN samples; no fill-count compensation.
REQ-022 score = min(avg, 16'hFFFF); score_valid pulses exactly 3 cycles after the smp_valid cycle; back-to-back smp_valid supported at one sample per cycle.
REQ-023 Per-threshold persistence counters count consecutive scores >= threshold; counter resets to 0 on any score below threshold and saturates at persist.
REQ-024 persist = 0 behaves as 1.
REQ-025 NORMAL -> WARN: warn counter reaches persist.
REQ-026 NORMAL or WARN -> EMERG: emerg counter reaches persist; takes priority when both reach persist on the same score.
REQ-027 EMERG -> WARN: score < emerg_th - hyst (floor 0) and score >= warn_th.
REQ-028 EMERG or WARN -> NORMAL: score < warn_th - hyst (floor 0).
REQ-029 State evaluated only on score_valid; level updates in the same cycle as score_valid.
REQ-030 Pending bits: pend[0] set on entry to WARN from NORMAL; pend[1] set on entry to EMERG; both sticky until irq_ack.
REQ-031 Set and irq_ack in the same cycle: set wins; other pending bits clear.
REQ-032 irq = 10 if pend[1] & ~irq_mask[1]; else 01 if pend[0] & ~irq_mask[0]; else 00.
REQ-033 Masking never clears pend; unmasking exposes a still-pending bit immediately.
REQ-034 Config writes mid-stream never flush the window; new weights apply from the next sample entering stage 1.

Reset
REQ-035 rst clears buffer, acc, pointer, pipeline valids, counters, and pend; sets score = 0, score_valid = 0, level = NORMAL, irq = 00.
REQ-036 rst restores weights to 1, warn_th and emerg_th to 16'hFFFF, persist to 1, hyst to 0.
REQ-037 rst mid-stream discards in-flight samples; no score_valid follows for them.

Verification (defaults NCH=4, DW=8, WIN=8; weights 2,3,1,4; warn 100; emerg 180; persist 2; hyst 10)
REQ-038 Constant samples 40,-20,20,10 each cycle -> inst 200; scores 25,50,...,200; level WARN at the 5th score, EMERG at the 9th; irq 01 then 10.
REQ-039 After EMERG, samples all zero -> score decays; EMERG->WARN when score < 170, ->NORMAL when score < 90.
REQ-040 Channel 0 = -128, weight 1, others 0, constant -> inst 128; no overflow; score saturates at 128.
REQ-041 irq_mask = 10 during emergency -> irq 00 if warning not pending; unmask -> irq 10 next cycle; irq_ack -> irq 00.
REQ-042 Threshold crossed for one score only, then dropped -> no level change, irq stays 00.
REQ-043 rst asserted 1 cycle after smp_valid -> no score_valid; all outputs at reset values next cycle.
